// File: rtl/grover_measure.sv
// Measurement stage for a Grover search engine: scans eight Q1.6 amplitudes,
// reports the most probable index, its probability and the total probability.
module grover_measure #(
    parameter int NUM_SAMPLE     = 8,
    parameter int FIXEDPOINT_BIT = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    input  logic                             clear,
    input  logic [2:0]                       target_search,
    input  logic signed [FIXEDPOINT_BIT-1:0] a0,
    input  logic signed [FIXEDPOINT_BIT-1:0] a1,
    input  logic signed [FIXEDPOINT_BIT-1:0] a2,
    input  logic signed [FIXEDPOINT_BIT-1:0] a3,
    input  logic signed [FIXEDPOINT_BIT-1:0] a4,
    input  logic signed [FIXEDPOINT_BIT-1:0] a5,
    input  logic signed [FIXEDPOINT_BIT-1:0] a6,
    input  logic signed [FIXEDPOINT_BIT-1:0] a7,
    output logic                             busy,
    output logic                             result_valid,
    output logic [2:0]                       meas_idx,
    output logic [2*FIXEDPOINT_BIT-1:0]      meas_prob,
    output logic [2*FIXEDPOINT_BIT+1:0]      prob_sum,
    output logic                             hit,
    output logic [7:0]                       led
);

    localparam int SQ_W  = 2 * FIXEDPOINT_BIT;
    localparam int SUM_W = SQ_W + 2;
    localparam logic [2:0] LAST = 3'(NUM_SAMPLE - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t state, next_state;

    logic                             prev_valid;
    logic                             trigger;
    logic [2:0]                       cnt;
    logic [2:0]                       tgt;
    logic signed [FIXEDPOINT_BIT-1:0] shadow [8];
    logic [SUM_W-1:0]                 acc_sum;
    logic [SQ_W-1:0]                  max_prob;
    logic [2:0]                       max_idx;

    logic signed [FIXEDPOINT_BIT-1:0] sample;
    logic signed [SQ_W-1:0]           ext;
    logic signed [SQ_W-1:0]           sq_s;
    logic [SQ_W-1:0]                  sq;
    logic [SUM_W-1:0]                 new_sum;
    logic                             take;
    logic [SQ_W-1:0]                  best_prob;
    logic [2:0]                       best_idx;

    assign trigger = in_valid & ~prev_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: if (trigger) next_state = SCAN;
            SCAN:       if (cnt == LAST) next_state = DONE;
            default:    next_state = IDLE;
        endcase
        if (clear) next_state = IDLE;
    end

    // Squares fit in SQ_W bits even for the most negative amplitude.
    always_comb begin
        sample    = shadow[cnt];
        ext       = SQ_W'(sample);
        sq_s      = ext * ext;
        sq        = sq_s;
        new_sum   = acc_sum + SUM_W'(sq);
        take      = sq > max_prob;
        best_prob = take ? sq  : max_prob;
        best_idx  = take ? cnt : max_idx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_valid   <= 1'b0;
            cnt          <= '0;
            tgt          <= '0;
            acc_sum      <= '0;
            max_prob     <= '0;
            max_idx      <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            meas_idx     <= '0;
            meas_prob    <= '0;
            prob_sum     <= '0;
            hit          <= 1'b0;
            for (int i = 0; i < 8; i++) shadow[i] <= '0;
        end else if (clear) begin
            prev_valid   <= 1'b0;
            cnt          <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            hit          <= 1'b0;
        end else begin
            prev_valid <= in_valid;
            case (state)
                IDLE, DONE: begin
                    if (trigger) begin
                        shadow[0]    <= a0;
                        shadow[1]    <= a1;
                        shadow[2]    <= a2;
                        shadow[3]    <= a3;
                        shadow[4]    <= a4;
                        shadow[5]    <= a5;
                        shadow[6]    <= a6;
                        shadow[7]    <= a7;
                        tgt          <= target_search;
                        acc_sum      <= '0;
                        max_prob     <= '0;
                        max_idx      <= '0;
                        cnt          <= '0;
                        result_valid <= 1'b0;
                        hit          <= 1'b0;
                        busy         <= 1'b1;
                    end
                end
                SCAN: begin
                    acc_sum  <= new_sum;
                    max_prob <= best_prob;
                    max_idx  <= best_idx;
                    cnt      <= cnt + 3'd1;
                    if (cnt == LAST) begin
                        meas_idx     <= best_idx;
                        meas_prob    <= best_prob;
                        prob_sum     <= new_sum;
                        hit          <= (best_idx == tgt);
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        cnt          <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        led = '0;
        if (result_valid) led[meas_idx] = 1'b1;
    end

endmodule

// File: tb/tb_grover_measure.sv
// Directed bench for grover_measure: vector table plus clear, reset and
// mid-scan disturbance sequences.
module tb_grover_measure;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            clear;
    logic [2:0]      target_search;
    logic [7:0][7:0] av;
    logic            busy;
    logic            result_valid;
    logic [2:0]      meas_idx;
    logic [15:0]     meas_prob;
    logic [17:0]     prob_sum;
    logic            hit;
    logic [7:0]      led;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0][7:0] a;
        logic [2:0]      tgt;
        logic [2:0]      idx;
        logic [15:0]     prob;
        logic [17:0]     sum;
        logic            hit;
    } vec_t;

    vec_t vecs [7];

    grover_measure dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .clear         (clear),
        .target_search (target_search),
        .a0            (av[0]),
        .a1            (av[1]),
        .a2            (av[2]),
        .a3            (av[3]),
        .a4            (av[4]),
        .a5            (av[5]),
        .a6            (av[6]),
        .a7            (av[7]),
        .busy          (busy),
        .result_valid  (result_valid),
        .meas_idx      (meas_idx),
        .meas_prob     (meas_prob),
        .prob_sum      (prob_sum),
        .hit           (hit),
        .led           (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int x0, input int x1, input int x2,
                                input int x3, input int x4, input int x5,
                                input int x6, input int x7, input int t,
                                input int idx, input int prob, input int sum,
                                input int h);
        vec_t v;
        v.a[0] = x0[7:0];
        v.a[1] = x1[7:0];
        v.a[2] = x2[7:0];
        v.a[3] = x3[7:0];
        v.a[4] = x4[7:0];
        v.a[5] = x5[7:0];
        v.a[6] = x6[7:0];
        v.a[7] = x7[7:0];
        v.tgt  = t[2:0];
        v.idx  = idx[2:0];
        v.prob = prob[15:0];
        v.sum  = sum[17:0];
        v.hit  = h[0];
        return v;
    endfunction

    task automatic check_result(input vec_t v, input string tag);
        logic [7:0] exp_led;
        exp_led = 8'd1 << v.idx;
        chk({tag, ".result_valid"}, result_valid, 1);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".meas_idx"}, meas_idx, v.idx);
        chk({tag, ".meas_prob"}, meas_prob, v.prob);
        chk({tag, ".prob_sum"}, prob_sum, v.sum);
        chk({tag, ".hit"}, hit, v.hit);
        chk({tag, ".led"}, led, exp_led);
    endtask

    // Counts edges from the capture edge until result_valid, bounded.
    task automatic wait_result(input string tag);
        int edges;
        edges = 0;
        while (!result_valid && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        chk({tag, ".latency"}, edges, 8);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        av            = v.a;
        target_search = v.tgt;
        in_valid      = 1'b1;
        @(posedge clk); #1;
        chk({tag, ".busy_on_capture"}, busy, 1);
        chk({tag, ".rv_on_capture"}, result_valid, 0);
        @(negedge clk);
        in_valid = 1'b0;
        wait_result(tag);
        check_result(v, tag);
    endtask

    initial begin
        vec_t v;
        int   e;
        vecs[0] = mk(23, 23, 23, 23, 23, 23, 23, 23, 2, 0, 529, 4232, 0);
        vecs[1] = mk(10, 10, 10, 10, 10, -60, 10, 10, 5, 5, 3600, 4300, 1);
        vecs[2] = mk(0, 0, 0, -128, 0, 0, 0, 0, 3, 3, 16384, 16384, 1);
        vecs[3] = mk(-128, -128, -128, -128, -128, -128, -128, -128,
                     7, 0, 16384, 131072, 0);
        vecs[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        vecs[5] = mk(1, 1, -40, 1, 1, 1, 40, 1, 6, 2, 1600, 3206, 0);
        vecs[6] = mk(1, 2, 3, 4, 5, 6, 7, -8, 7, 7, 64, 204, 1);

        rst           = 1'b0;
        clear         = 1'b0;
        in_valid      = 1'b1;
        av            = vecs[0].a;
        target_search = vecs[0].tgt;
        #12;
        chk("reset.busy", busy, 0);
        chk("reset.result_valid", result_valid, 0);
        chk("reset.meas_idx", meas_idx, 0);
        chk("reset.meas_prob", meas_prob, 0);
        chk("reset.prob_sum", prob_sum, 0);
        chk("reset.hit", hit, 0);
        chk("reset.led", led, 0);

        // in_valid already high at release counts as a trigger
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("first_edge.busy", busy, 1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_result("first_edge");
        check_result(vecs[0], "first_edge");

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Disturb inputs and in_valid during the scan; hold in_valid in DONE
        v = vecs[1];
        @(negedge clk);
        av            = v.a;
        target_search = v.tgt;
        in_valid      = 1'b1;
        @(posedge clk); #1;
        e = 0;
        while (!result_valid && e < 20) begin
            @(posedge clk); #1;
            e++;
            if (e == 2) begin
                @(negedge clk);
                av            = {8{8'd100}};
                target_search = 3'd0;
                in_valid      = 1'b0;
            end else if (e == 3) begin
                @(negedge clk);
                in_valid = 1'b1;
            end
        end
        chk("disturb.latency", e, 8);
        check_result(v, "disturb");
        repeat (10) @(posedge clk);
        #1;
        chk("hold.busy", busy, 0);
        check_result(v, "hold");

        // Clear wins over a simultaneous trigger
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        clear    = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk("clear.result_valid", result_valid, 0);
        chk("clear.led", led, 0);
        chk("clear.busy", busy, 0);
        chk("clear.hit", hit, 0);
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("clear.idle_busy", busy, 0);
        run_vec(vecs[0], "after_clear");

        // Reset on the fourth scan edge
        @(negedge clk);
        av            = vecs[1].a;
        target_search = vecs[1].tgt;
        in_valid      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midreset.busy", busy, 0);
        chk("midreset.result_valid", result_valid, 0);
        chk("midreset.meas_idx", meas_idx, 0);
        chk("midreset.meas_prob", meas_prob, 0);
        chk("midreset.prob_sum", prob_sum, 0);
        chk("midreset.hit", hit, 0);
        chk("midreset.led", led, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("post_reset.result_valid", result_valid, 0);
        chk("post_reset.busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
